msg_frame_stat: RTL

//  Parametrised successor to the fixed byte-stream message identification/statistics pair.
//  - Hunts a DW-bit symbol stream for a configurable header and reads a one-symbol length field.
//  - Forwards the payload with sop/eop/vld framing and an optional checksum verdict.
//  - Maintains saturating packet and error counters.
//  - Sits between the raw receive interface and downstream packet consumers.

---
 rtl/msg_frame_stat.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/msg_frame_stat.sv
// Header-hunting framer: finds HEAD_PAT, reads a length symbol, forwards payload with sop/eop/vld, counts good/bad packets.
// Optional trailing checksum symbol enabled by defining CHKSUM_EN; outputs registered, 1-cycle latency, no backpressure.
module msg_frame_stat #(
  parameter int                     DW       = 8,
  parameter int                     HEAD_NUM = 2,
  parameter logic [HEAD_NUM*DW-1:0] HEAD_PAT = 16'h55D5,
  parameter int                     MAX_LEN  = 64,
  parameter int                     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    din,
  input  logic             din_vld,
  input  logic             stat_clr,
  output logic [DW-1:0]    dout,
  output logic             dout_sop,
  output logic             dout_eop,
  output logic             dout_vld,
  output logic             pkt_ok,
  output logic             pkt_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int HW = HEAD_NUM * DW;
  localparam logic [DW-1:0] MAX_L = DW'(MAX_LEN);

`ifdef CHKSUM_EN
  typedef enum logic [1:0] {HUNT, LEN, DATA, CHK} state_t;
`else
  typedef enum logic [1:0] {HUNT, LEN, DATA} state_t;
`endif

  state_t        state, state_nxt;
  logic [HW-1:0] hdr_sr, hdr_nxt, hdr_shift;
  logic [DW-1:0] hdr_drop;
  logic [DW-1:0] len_r, len_nxt;
  logic [DW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          vld_nxt, sop_nxt, eop_nxt, ok_nxt, err_nxt;
  logic          unused_hdr;
`ifdef CHKSUM_EN
  logic [DW-1:0] sum, sum_nxt;
`endif

  // The oldest symbol falls off the top of the header window.
  assign {hdr_drop, hdr_shift} = {hdr_sr, din};
  assign unused_hdr = ^hdr_drop;
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    hdr_nxt   = hdr_sr;
    len_nxt   = len_r;
    cnt_nxt   = cnt;
    vld_nxt   = 1'b0;
    sop_nxt   = 1'b0;
    eop_nxt   = 1'b0;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
`ifdef CHKSUM_EN
    sum_nxt   = sum;
`endif
    if (din_vld) begin
      case (state)
        HUNT: begin
          if (hdr_shift == HEAD_PAT) begin
            state_nxt = LEN;
            hdr_nxt   = '0;
          end else begin
            hdr_nxt = hdr_shift;
          end
        end
        LEN: begin
          len_nxt = din;
          cnt_nxt = '0;
`ifdef CHKSUM_EN
          sum_nxt = '0;
`endif
          if (din != '0 && din <= MAX_L) begin
            state_nxt = DATA;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = HUNT;
          end
        end
        DATA: begin
          vld_nxt = 1'b1;
          sop_nxt = (cnt == '0);
          cnt_nxt = cnt_inc;
`ifdef CHKSUM_EN
          sum_nxt = sum + din;
`endif
          if (cnt_inc == len_r) begin
            eop_nxt = 1'b1;
`ifdef CHKSUM_EN
            state_nxt = CHK;
`else
            ok_nxt    = 1'b1;
            state_nxt = HUNT;
`endif
          end
        end
`ifdef CHKSUM_EN
        CHK: begin
          ok_nxt    = (din == sum);
          err_nxt   = (din != sum);
          state_nxt = HUNT;
        end
`endif
        default: state_nxt = HUNT;
      endcase
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= HUNT;
      hdr_sr   <= '0;
      len_r    <= '0;
      cnt      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
`ifdef CHKSUM_EN
      sum      <= '0;
`endif
    end else begin
      state    <= state_nxt;
      hdr_sr   <= hdr_nxt;
      len_r    <= len_nxt;
      cnt      <= cnt_nxt;
      dout_vld <= vld_nxt;
      dout_sop <= sop_nxt;
      dout_eop <= eop_nxt;
      pkt_ok   <= ok_nxt;
      pkt_err  <= err_nxt;
      if (vld_nxt) dout <= din;
`ifdef CHKSUM_EN
      sum      <= sum_nxt;
`endif
    end
  end

  // Clear wins over a coincident increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst_n || stat_clr) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (ok_nxt && pkt_cnt != '1)  pkt_cnt <= pkt_cnt + 1'b1;
      if (err_nxt && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
